pipelined_adder: RTL and testbench

//  Parametrised, pipelined segmented-carry adder/subtractor. Successor to the
//  32-bit combinational ripple-carry adder. Splits WIDTH into STAGES equal

---
 rtl/pipelined_adder.sv | 168 ++++++++++++++++
 tb/tb_pipelined_adder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
//
// Pipelined segmented-carry adder/subtractor. WIDTH is split into STAGES
// equal segments of SEG = WIDTH/STAGES bits. Stage k adds segment k using the
// carry registered by stage k-1. Each stage register carries the full operand
// and partial-result words, so later operand segments are skewed forward and
// finished result segments are de-skewed. Every transaction therefore leaves
// the last stage fully aligned.
//
// A single advance signal stalls the whole pipeline whenever the output holds
// data that the consumer has not taken.
//
// Parameters:
//   WIDTH   operand/result width; must be a multiple of STAGES
//   STAGES  pipeline depth (number of carry segments), >= 1
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   inValid    operands valid
//   inReady    block accepts operands this cycle
//   operA      operand A
//   operB      operand B
//   Cin        carry in (ignored when subMode = 1)
//   subMode    0: A+B+Cin, 1: A-B
//   outValid   resultOUT/Cout (and Ovf) valid
//   outReady   consumer accepts the result this cycle
//   resultOUT  sum/difference modulo 2^WIDTH
//   Cout       carry out of the MSB (subtract: 1 = no borrow)
//   Ovf        signed overflow; only present when OVERFLOW_FLAG_EN is defined
//
// Build option:
//   OVERFLOW_FLAG_EN  adds the registered Ovf output
// ---------------------------------------------------------------------------
module pipelined_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inValid,
   output logic             inReady,
   input  logic [WIDTH-1:0] operA,
   input  logic [WIDTH-1:0] operB,
   input  logic             Cin,
   input  logic             subMode,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] resultOUT,
   output logic             Cout
`ifdef OVERFLOW_FLAG_EN
   ,
   output logic             Ovf
`endif
);

   localparam int SEG = WIDTH / STAGES;

   if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_param_check
      $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
   end

   // Stage register outputs, one element per stage.
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] r_q [STAGES];
   logic             c_q [STAGES];
   logic             v_q [STAGES];

   // The pipeline moves as one unit. It holds only when the output is full
   // and the consumer is not taking it.
   logic advance;
   assign advance  = !v_q[STAGES-1] || outReady;
   assign inReady  = advance;

`ifdef OVERFLOW_FLAG_EN
   logic ovf_reg;
`endif

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH-1:0] r_in;
      logic             c_in;
      logic             v_in;

      if (gi == 0) begin : g_first
         // Subtraction is A + ~B + 1. The +1 rides in as the stage-0 carry.
         assign a_in = operA;
         assign b_in = subMode ? ~operB : operB;
         assign c_in = subMode ? 1'b1 : Cin;
         assign v_in = inValid;
         assign r_in = '0;
      end else begin : g_next
         assign a_in = a_q[gi-1];
         assign b_in = b_q[gi-1];
         assign c_in = c_q[gi-1];
         assign v_in = v_q[gi-1];
         assign r_in = r_q[gi-1];
      end

      // One extra bit holds the segment's carry-out.
      logic [SEG:0]     seg_sum;
      logic [WIDTH-1:0] r_next;

      assign seg_sum = {1'b0, a_in[gi*SEG +: SEG]}
                     + {1'b0, b_in[gi*SEG +: SEG]}
                     + {{SEG{1'b0}}, c_in};

      always_comb begin
         r_next = r_in;
         r_next[gi*SEG +: SEG] = seg_sum[SEG-1:0];
      end

      logic [WIDTH-1:0] a_reg;
      logic [WIDTH-1:0] b_reg;
      logic [WIDTH-1:0] r_reg;
      logic             c_reg;
      logic             v_reg;

      always_ff @(posedge clk) begin
         if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            r_reg <= '0;
            c_reg <= 1'b0;
            v_reg <= 1'b0;
         end else if (advance) begin
            a_reg <= a_in;
            b_reg <= b_in;
            r_reg <= r_next;
            c_reg <= seg_sum[SEG];
            v_reg <= v_in;
         end
      end

      assign a_q[gi] = a_reg;
      assign b_q[gi] = b_reg;
      assign r_q[gi] = r_reg;
      assign c_q[gi] = c_reg;
      assign v_q[gi] = v_reg;

`ifdef OVERFLOW_FLAG_EN
      if (gi == STAGES - 1) begin : g_ovf
         // Carry into the MSB is recovered from the MSB sum bit:
         // a ^ b ^ sum. Overflow is that carry XOR the carry out.
         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_reg <= 1'b0;
            end else if (advance) begin
               ovf_reg <= a_in[WIDTH-1] ^ b_in[WIDTH-1]
                        ^ seg_sum[SEG-1] ^ seg_sum[SEG];
            end
         end
      end
`endif
   end

   assign outValid  = v_q[STAGES-1];
   assign resultOUT = r_q[STAGES-1];
   assign Cout      = c_q[STAGES-1];

`ifdef OVERFLOW_FLAG_EN
   assign Ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_adder
//
// Directed-vector bench for pipelined_adder (WIDTH=32, STAGES=4).
// The stimulus process pushes a hand-computed expected result for every
// accepted transaction. A separate monitor pops and compares each result
// the DUT hands over (outValid && outReady).
// ---------------------------------------------------------------------------
module tb_pipelined_adder;

   localparam int WIDTH  = 32;
   localparam int STAGES = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             inValid;
   logic             inReady;
   logic [WIDTH-1:0] operA;
   logic [WIDTH-1:0] operB;
   logic             Cin;
   logic             subMode;
   logic             outValid;
   logic             outReady;
   logic [WIDTH-1:0] resultOUT;
   logic             Cout;
`ifdef OVERFLOW_FLAG_EN
   logic             Ovf;
`endif

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             cout;
      logic             ovf;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst       (rst),
      .inValid   (inValid),
      .inReady   (inReady),
      .operA     (operA),
      .operB     (operB),
      .Cin       (Cin),
      .subMode   (subMode),
      .outValid  (outValid),
      .outReady  (outReady),
      .resultOUT (resultOUT),
      .Cout      (Cout)
`ifdef OVERFLOW_FLAG_EN
      ,
      .Ovf       (Ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Drives one transaction from a falling edge and waits until it is
   // accepted. It returns just after the accepting rising edge with inValid
   // dropped, so back-to-back calls give one transaction per cycle.
   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub,
                       input logic [WIDTH-1:0] er, input logic ec, input logic eo,
                       output int waits);
      exp_t e;
      @(negedge clk);
      operA   = a;
      operB   = b;
      Cin     = cin;
      subMode = sub;
      inValid = 1'b1;
      #1;
      waits = 0;
      while (!inReady && waits < 50) begin
         @(negedge clk);
         #1;
         waits++;
      end
      if (!inReady) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=inReady_low required=accept a=%h", a);
         inValid = 1'b0;
      end else begin
         e.res  = er;
         e.cout = ec;
         e.ovf  = eo;
         sb_q.push_back(e);
         @(posedge clk);
         #1;
         inValid = 1'b0;
         $display("send a=%h b=%h cin=%0b sub=%0b exp=%h/%0b waits=%0d", a, b, cin, sub, er, ec, waits);
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", 64'(sb_q.size()), 64'd0);
   endtask

   // Monitor: compares every handed-over result against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (rst === 1'b0 && outValid === 1'b1 && outReady === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%h required=none", resultOUT);
         end else begin
            e = sb_q.pop_front();
            $display("recv res=%h cout=%0b exp=%h/%0b", resultOUT, Cout, e.res, e.cout);
            chk("result", 64'(resultOUT), 64'(e.res));
            chk("cout", 64'(Cout), 64'(e.cout));
`ifdef OVERFLOW_FLAG_EN
            chk("ovf", 64'(Ovf), 64'(e.ovf));
`endif
         end
      end
   end

   initial begin
      int w;
      int lat;
      exp_t head;
      rst      = 1'b1;
      inValid  = 1'b0;
      operA    = '0;
      operB    = '0;
      Cin      = 1'b0;
      subMode  = 1'b0;
      outReady = 1'b1;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outValid", 64'(outValid), 64'd0);
      chk("reset_result", 64'(resultOUT), 64'd0);
      chk("reset_cout", 64'(Cout), 64'd0);
      chk("reset_inReady", 64'(inReady), 64'd1);
`ifdef OVERFLOW_FLAG_EN
      chk("reset_ovf", 64'(Ovf), 64'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

      // Carry ripples through all four segments; latency check.
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, w);
      lat = 1;
      @(negedge clk);
      #1;
      while (!outValid && lat < 20) begin
         @(negedge clk);
         #1;
         lat++;
      end
      chk("latency", 64'(lat), 64'(STAGES));
      wait_drain();

      // Back-to-back at full throughput.
      send(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, w);
      send(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0, w);
      chk("b2b_no_wait_2", 64'(w), 64'd0);
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, w);
      chk("b2b_no_wait_3", 64'(w), 64'd0);

      // Subtract; Cin must be ignored.
      send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, w);
      send(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, w);
      send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, w);
      send(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0, w);
      send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, w);

      // Segment boundaries and signed overflow.
      send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, w);
      send(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, w);
      send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, w);
      send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, w);
      send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, w);
      wait_drain();

      // Stall: fill with the consumer blocked, hold, then drain in order.
      @(negedge clk);
      outReady = 1'b0;
      send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 32'h3333_3333, 1'b0, 1'b0, w);
      send(32'h0100_0000, 32'h0F00_0000, 1'b0, 1'b0, 32'h1000_0000, 1'b0, 1'b0, w);
      send(32'hF000_0000, 32'h2000_0000, 1'b0, 1'b0, 32'h1000_0000, 1'b1, 1'b0, w);
      send(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, w);
      chk("fill_no_wait", 64'(w), 64'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         head = sb_q[0];
         chk("stall_inReady", 64'(inReady), 64'd0);
         chk("stall_outValid", 64'(outValid), 64'd1);
         chk("stall_result", 64'(resultOUT), 64'(head.res));
      end
      @(negedge clk);
      outReady = 1'b1;
      wait_drain();

      // Reset with three transactions in flight.
      send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0, w);
      send(32'h0000_0004, 32'h0000_0005, 1'b0, 1'b0, 32'h0000_0009, 1'b0, 1'b0, w);
      send(32'h0000_0006, 32'h0000_0007, 1'b0, 1'b0, 32'h0000_000D, 1'b0, 1'b0, w);
      @(negedge clk);
      rst = 1'b1;
      sb_q.delete();
      @(posedge clk);
      #1;
      chk("midrst_outValid", 64'(outValid), 64'd0);
      chk("midrst_result", 64'(resultOUT), 64'd0);
      chk("midrst_inReady", 64'(inReady), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // Pipeline still works after the mid-flight reset.
      send(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_0031, 1'b0, 1'b0, w);
      wait_drain();
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
